dds_sine_tri_gen: RTL and testbench

Direct digital synthesis front end that produces the signed sine reference `Sine_out` and the signed triangle carrier `Tri_out` consumed by the PWM/dead-time stage. It combines a phase accumulator, a quarter-wave sine ROM and a free-running up/down triangle counter. It supports glitch-free frequency retuning that is applied only at the sine phase wrap. It sits directly upstream of the PWM stage and drives its inputs without any glue logic.

---
 rtl/dds_pkg.sv | 47 ++++
 rtl/dds_sine_tri_gen_if.sv | 32 +++
 rtl/sine_quarter_rom.sv | 35 +++
 rtl/dds_sine_tri_gen.sv | 151 +++++++++++++++
 tb/tb_dds_sine_tri_gen.sv | 316 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/dds_pkg.sv
// Shared definitions for the DDS sine/triangle generator.
// Holds the datapath widths, the sine quadrant encoding, the triangle direction
// states and the formula used to generate the quarter-wave sine ROM contents.
package dds_pkg;

    localparam int unsigned DDS_PHASE_W = 32;  // phase accumulator width
    localparam int unsigned DDS_LUT_AW  = 10;  // quarter-wave ROM address width
    localparam int unsigned SINE_W      = 16;  // signed sine sample width
    localparam int unsigned TRI_W       = 17;  // signed triangle carrier width
    localparam int unsigned TRI_CALC_W  = 18;  // triangle intermediate width, never wraps
    localparam int unsigned ROM_DW      = 15;  // unsigned ROM magnitude width

    // Quadrant taken from the top two phase bits.
    typedef enum logic [1:0] {
        QuadPosRise = 2'd0,
        QuadPosFall = 2'd1,
        QuadNegFall = 2'd2,
        QuadNegRise = 2'd3
    } quad_e;

    typedef enum logic {
        DirUp   = 1'b0,
        DirDown = 1'b1
    } tri_dir_e;

    // ROM entry i = round(ROM_AMPL * sin(pi/2 * (i + 0.5) / depth)).
    localparam real ROM_AMPL    = 32767.0;
    localparam real ROM_HALF_PI = 1.5707963267948966;

    function automatic logic [ROM_DW-1:0] sine_rom_entry(input int unsigned idx,
                                                         input int unsigned depth);
        real phase;
        phase = ROM_HALF_PI * (real'(idx) + 0.5) / real'(depth);
        return ROM_DW'($rtoi(ROM_AMPL * $sin(phase) + 0.5));
    endfunction

    // Falling quadrants walk the quarter-wave table backwards.
    function automatic logic quad_mirror(input quad_e q);
        return (q == QuadPosFall) || (q == QuadNegRise);
    endfunction

    // Second half of the period is the negated first half.
    function automatic logic quad_negate(input quad_e q);
        return (q == QuadNegFall) || (q == QuadNegRise);
    endfunction

endpackage

// File: rtl/dds_sine_tri_gen_if.sv
// Control/status bundle of the DDS generator.
// master: drives en, ftw_in, ftw_wr; observes the waveform outputs.
// slave : the generator itself.
// Signals: en (advance), ftw_in/ftw_wr (retune request), ftw_pending (retune waiting
// for the phase wrap), Sine_out/sine_valid (sine sample), Tri_out/carrier_valley
// (triangle carrier and its valley pulse).
interface dds_sine_tri_gen_if
    import dds_pkg::*;
#(
    parameter int unsigned PHASE_W = DDS_PHASE_W
) ();

    logic                     en;
    logic [PHASE_W-1:0]       ftw_in;
    logic                     ftw_wr;
    logic                     ftw_pending;
    logic signed [SINE_W-1:0] Sine_out;
    logic signed [TRI_W-1:0]  Tri_out;
    logic                     sine_valid;
    logic                     carrier_valley;

    modport master (
        output en, ftw_in, ftw_wr,
        input  ftw_pending, Sine_out, Tri_out, sine_valid, carrier_valley
    );

    modport slave (
        input  en, ftw_in, ftw_wr,
        output ftw_pending, Sine_out, Tri_out, sine_valid, carrier_valley
    );

endinterface

// File: rtl/sine_quarter_rom.sv
// Synchronous quarter-wave sine ROM.
// Ports: clk_i clock, rst_i synchronous reset of the read register,
// addr_i table index, data_o registered unsigned magnitude (one cycle latency).
module sine_quarter_rom
    import dds_pkg::*;
#(
    parameter int unsigned AddrW = DDS_LUT_AW
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [AddrW-1:0]  addr_i,
    output logic [ROM_DW-1:0] data_o
);

    localparam int unsigned Depth = 1 << AddrW;

    logic [ROM_DW-1:0] rom_w [Depth];
    logic [ROM_DW-1:0] data_q;

    // Contents are constants of elaboration; synthesis folds them into a ROM.
    for (genvar i = 0; i < Depth; i++) begin : g_rom
        assign rom_w[i] = sine_rom_entry(i, Depth);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            data_q <= '0;
        end else begin
            data_q <= rom_w[addr_i];
        end
    end

    assign data_o = data_q;

endmodule

// File: rtl/dds_sine_tri_gen.sv
// DDS front end: phase accumulator with wrap-synchronous retune, 3-stage quarter-wave
// sine pipeline and a free-running up/down triangle carrier.
// Ports: clk, reset (synchronous, active high), bus (slave side of dds_sine_tri_gen_if).
module dds_sine_tri_gen
    import dds_pkg::*;
#(
    parameter int unsigned        PHASE_W   = DDS_PHASE_W,
    parameter int unsigned        LUT_AW    = DDS_LUT_AW,
    parameter int                 TRI_PEAK  = 32767,
    parameter int                 TRI_STEP  = 64,
    parameter logic [PHASE_W-1:0] FTW_RESET = '0
) (
    input logic                clk,
    input logic                reset,
    dds_sine_tri_gen_if.slave  bus
);

    localparam logic signed [TRI_CALC_W-1:0] PeakS    = TRI_CALC_W'(TRI_PEAK);
    localparam logic signed [TRI_CALC_W-1:0] NegPeakS = -PeakS;
    localparam logic signed [TRI_CALC_W-1:0] StepS    = TRI_CALC_W'(TRI_STEP);

    // Accumulator and retune
    logic [PHASE_W-1:0] acc_q, acc_d;
    logic [PHASE_W-1:0] ftw_active_q, ftw_active_d;
    logic [PHASE_W-1:0] ftw_next_q, ftw_next_d;
    logic               pending_q, pending_d;
    logic [PHASE_W:0]   acc_sum;
    logic               wrap;

    assign acc_sum = {1'b0, acc_q} + {1'b0, ftw_active_q};
    assign wrap    = bus.en & acc_sum[PHASE_W];

    always_comb begin
        acc_d        = acc_q;
        ftw_active_d = ftw_active_q;
        ftw_next_d   = ftw_next_q;
        pending_d    = pending_q;
        if (bus.en) begin
            acc_d = acc_sum[PHASE_W-1:0];
        end
        // Commit uses the word pending before this cycle; a same-cycle write queues behind it.
        if (wrap && pending_q) begin
            ftw_active_d = ftw_next_q;
            pending_d    = 1'b0;
        end
        if (bus.ftw_wr) begin
            ftw_next_d = bus.ftw_in;
            pending_d  = 1'b1;
        end
    end

    // Triangle carrier
    tri_dir_e                      dir_q, dir_d;
    logic signed [TRI_W-1:0]       tri_q, tri_d;
    logic                          valley_q, valley_d;
    logic signed [TRI_CALC_W-1:0]  tri_ext, tri_up, tri_dn;

    assign tri_ext = {tri_q[TRI_W-1], tri_q};
    assign tri_up  = tri_ext + StepS;
    assign tri_dn  = tri_ext - StepS;

    always_comb begin
        tri_d    = tri_q;
        dir_d    = dir_q;
        valley_d = 1'b0;
        if (bus.en) begin
            unique case (dir_q)
                DirUp: begin
                    if (tri_up >= PeakS) begin
                        tri_d = PeakS[TRI_W-1:0];
                        dir_d = DirDown;
                    end else begin
                        tri_d = tri_up[TRI_W-1:0];
                    end
                end
                DirDown: begin
                    if (tri_dn <= NegPeakS) begin
                        tri_d    = NegPeakS[TRI_W-1:0];
                        dir_d    = DirUp;
                        valley_d = 1'b1;
                    end else begin
                        tri_d = tri_dn[TRI_W-1:0];
                    end
                end
            endcase
        end
    end

    // Sine pipeline: S1 quadrant/address, S2 ROM read, S3 conditional negate.
    quad_e                     q0, q1_q, q2_q;
    logic [LUT_AW-1:0]         a0, addr_d, addr_q;
    logic [ROM_DW-1:0]         rom_data;
    logic signed [SINE_W-1:0]  sine_mag, sine_d, sine_q;
    logic                      v1_q, v2_q, v3_q;

    assign q0       = quad_e'(acc_q[PHASE_W-1 -: 2]);
    assign a0       = acc_q[PHASE_W-3 -: LUT_AW];
    assign addr_d   = quad_mirror(q0) ? ~a0 : a0;
    assign sine_mag = {1'b0, rom_data};
    assign sine_d   = quad_negate(q2_q) ? -sine_mag : sine_mag;

    sine_quarter_rom #(
        .AddrW (LUT_AW)
    ) u_rom (
        .clk_i  (clk),
        .rst_i  (reset),
        .addr_i (addr_q),
        .data_o (rom_data)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            acc_q        <= '0;
            ftw_active_q <= FTW_RESET;
            ftw_next_q   <= '0;
            pending_q    <= 1'b0;
            tri_q        <= '0;
            dir_q        <= DirUp;
            valley_q     <= 1'b0;
            q1_q         <= QuadPosRise;
            q2_q         <= QuadPosRise;
            addr_q       <= '0;
            sine_q       <= '0;
            v1_q         <= 1'b0;
            v2_q         <= 1'b0;
            v3_q         <= 1'b0;
        end else begin
            acc_q        <= acc_d;
            ftw_active_q <= ftw_active_d;
            ftw_next_q   <= ftw_next_d;
            pending_q    <= pending_d;
            tri_q        <= tri_d;
            dir_q        <= dir_d;
            valley_q     <= valley_d;
            q1_q         <= q0;
            q2_q         <= q1_q;
            addr_q       <= addr_d;
            sine_q       <= sine_d;
            v1_q         <= bus.en;
            v2_q         <= v1_q;
            v3_q         <= v2_q;
        end
    end

    assign bus.ftw_pending    = pending_q;
    assign bus.Sine_out       = sine_q;
    assign bus.sine_valid     = v3_q;
    assign bus.Tri_out        = tri_q;
    assign bus.carrier_valley = valley_q;

endmodule

// File: tb/tb_dds_sine_tri_gen.sv
// Self-checking bench for dds_sine_tri_gen: fixed vector table for the startup
// waveform, hand sequences for retune/hold/reset corners, and a randomized run
// checked every cycle against a behavioural model.
module tb_dds_sine_tri_gen;

    localparam longint unsigned TWO32 = 64'h1_0000_0000;
    localparam logic [31:0]     FTW0  = 32'h0040_0000;
    localparam int              PEAK  = 32767;
    localparam int              STEP  = 64;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    dds_sine_tri_gen_if #(.PHASE_W(32)) bus ();

    dds_sine_tri_gen #(
        .PHASE_W   (32),
        .LUT_AW    (10),
        .TRI_PEAK  (PEAK),
        .TRI_STEP  (STEP),
        .FTW_RESET (FTW0)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_vec  = 0;
    int n_fail = 0;

    // Behavioural model state
    typedef struct {
        int s;
        bit v;
    } samp_t;

    longint unsigned m_acc, m_ftw_act, m_ftw_next;
    bit              m_pend;
    int              m_tri;
    bit              m_up;
    samp_t           sq[$];
    int              e_sine;
    bit              e_valid, e_valley, e_zero;

    function automatic int sine_of(input longint unsigned acc);
        int  q, a, idx, mag;
        real r;
        q   = int'(acc >> 30);
        a   = int'((acc >> 20) & 64'd1023);
        idx = (q % 2 == 1) ? 1023 - a : a;
        r   = 32767.0 * $sin(3.141592653589793 * (real'(idx) + 0.5) / 2048.0);
        mag = $rtoi(r + 0.5);
        return (q >= 2) ? -mag : mag;
    endfunction

    function automatic bit will_wrap();
        return bus.en && (m_acc + m_ftw_act >= TWO32);
    endfunction

    task automatic model_step();
        samp_t it;
        longint unsigned sum;
        if (reset) begin
            m_acc = 0; m_ftw_act = FTW0; m_ftw_next = 0; m_pend = 0;
            m_tri = 0; m_up = 1;
            e_sine = 0; e_valid = 0; e_valley = 0; e_zero = 1;
            sq.delete();
            it.s = 0; it.v = 0;
            sq.push_back(it);
            sq.push_back(it);
        end else begin
            e_zero = 0;
            it = sq.pop_front();
            e_sine = it.s;
            e_valid = it.v;
            it.s = sine_of(m_acc);
            it.v = bus.en;
            sq.push_back(it);
            e_valley = 0;
            if (bus.en) begin
                sum = m_acc + m_ftw_act;
                m_acc = sum % TWO32;
                if (sum >= TWO32 && m_pend) begin
                    m_ftw_act = m_ftw_next;
                    m_pend = 0;
                end
                if (m_up) begin
                    if (m_tri + STEP >= PEAK) begin m_tri = PEAK; m_up = 0; end
                    else m_tri = m_tri + STEP;
                end else begin
                    if (m_tri - STEP <= -PEAK) begin m_tri = -PEAK; m_up = 1; e_valley = 1; end
                    else m_tri = m_tri - STEP;
                end
            end
            if (bus.ftw_wr) begin
                m_ftw_next = longint'(bus.ftw_in);
                m_pend = 1;
            end
        end
    endtask

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
        end
    endtask

    task automatic compare_all();
        check("tri_out", int'(bus.Tri_out), m_tri);
        check("carrier_valley", int'(bus.carrier_valley), int'(e_valley));
        check("ftw_pending", int'(bus.ftw_pending), int'(m_pend));
        check("sine_valid", int'(bus.sine_valid), int'(e_valid));
        if (e_valid || e_zero) check("sine_out", int'(bus.Sine_out), e_sine);
    endtask

    task automatic step();
        model_step();
        @(posedge clk);
        @(negedge clk);
        compare_all();
    endtask

    // Write a tuning word and count cycles until the pending flag clears.
    task automatic measure(input logic [31:0] w, output int cnt);
        bus.ftw_in = w;
        bus.ftw_wr = 1'b1;
        step();
        bus.ftw_wr = 1'b0;
        cnt = 1;
        while (bus.ftw_pending && cnt < 5000) begin
            step();
            cnt++;
        end
    endtask

    typedef struct {
        string name;
        int    sel;  // 0 sine sample, 1 triangle, 2 valley
        int    idx;
        int    exp;
    } vec_t;

    vec_t vecs[$];
    int   sine_samp [0:1537];
    int   tri_samp  [0:1540];
    int   valley_samp [0:1540];

    function automatic void add_vec(input string n, input int s, input int i, input int e);
        vec_t v;
        v.name = n; v.sel = s; v.idx = i; v.exp = e;
        vecs.push_back(v);
    endfunction

    initial begin
        int cnt, t0, act;

        add_vec("sine_k0", 0, 0, 25);
        add_vec("sine_k1", 0, 1, 226);
        add_vec("sine_peak", 0, 256, 32767);
        add_vec("sine_k257", 0, 257, 32766);
        add_vec("sine_k511", 0, 511, 176);
        add_vec("sine_half", 0, 512, -25);
        add_vec("sine_k513", 0, 513, -226);
        add_vec("sine_trough", 0, 768, -32767);
        add_vec("sine_k769", 0, 769, -32766);
        add_vec("sine_wrap", 0, 1024, 25);
        add_vec("tri_n1", 1, 1, 64);
        add_vec("tri_n100", 1, 100, 6400);
        add_vec("tri_n511", 1, 511, 32704);
        add_vec("tri_clamp_hi", 1, 512, 32767);
        add_vec("tri_desc", 1, 513, 32703);
        add_vec("tri_n1535", 1, 1535, -32705);
        add_vec("tri_clamp_lo", 1, 1536, -32767);
        add_vec("tri_rise", 1, 1537, -32703);
        add_vec("valley_before", 2, 1535, 0);
        add_vec("valley_hit", 2, 1536, 1);
        add_vec("valley_after", 2, 1537, 0);

        reset = 1'b1;
        bus.en = 1'b0;
        bus.ftw_wr = 1'b0;
        bus.ftw_in = '0;
        step();
        step();
        check("rst_sine", int'(bus.Sine_out), 0);
        check("rst_tri", int'(bus.Tri_out), 0);
        check("rst_valid", int'(bus.sine_valid), 0);
        check("rst_valley", int'(bus.carrier_valley), 0);
        check("rst_pending", int'(bus.ftw_pending), 0);

        // Startup waveform with FTW = 2^22
        reset = 1'b0;
        bus.en = 1'b1;
        for (int j = 1; j <= 1540; j++) begin
            step();
            if (j == 2) check("first_valid_low", int'(bus.sine_valid), 0);
            if (j == 3) check("first_valid_high", int'(bus.sine_valid), 1);
            if (j >= 3) sine_samp[j-3] = int'(bus.Sine_out);
            tri_samp[j] = int'(bus.Tri_out);
            valley_samp[j] = int'(bus.carrier_valley);
        end
        foreach (vecs[i]) begin
            case (vecs[i].sel)
                0:       act = sine_samp[vecs[i].idx];
                1:       act = tri_samp[vecs[i].idx];
                default: act = valley_samp[vecs[i].idx];
            endcase
            check(vecs[i].name, act, vecs[i].exp);
        end

        // Retune mid-period: old period holds until the wrap
        bus.ftw_in = 32'h0080_0000;
        bus.ftw_wr = 1'b1;
        step();
        bus.ftw_wr = 1'b0;
        check("retune_pending_set", int'(bus.ftw_pending), 1);
        cnt = 0;
        while (bus.ftw_pending && cnt < 5000) begin
            step();
            cnt++;
        end
        check("retune_pending_clear", int'(bus.ftw_pending), 0);
        measure(32'h0080_0000, cnt);
        check("period_2p23", cnt, 512);

        // Two writes before the wrap: only the second one survives
        bus.ftw_in = 32'h0020_0000;
        bus.ftw_wr = 1'b1;
        step();
        bus.ftw_wr = 1'b0;
        cnt = 1;
        repeat (100) begin step(); cnt++; end
        bus.ftw_in = 32'h0100_0000;
        bus.ftw_wr = 1'b1;
        step();
        cnt++;
        bus.ftw_wr = 1'b0;
        while (bus.ftw_pending && cnt < 5000) begin
            step();
            cnt++;
        end
        check("two_write_period", cnt, 512);
        measure(32'h0040_0000, cnt);
        check("last_write_wins", cnt, 256);

        // Write landing exactly on the wrap cycle
        bus.ftw_in = 32'h0080_0000;
        bus.ftw_wr = 1'b1;
        step();
        bus.ftw_wr = 1'b0;
        for (int i = 0; i < 2000 && !will_wrap(); i++) step();
        bus.ftw_in = 32'h0100_0000;
        bus.ftw_wr = 1'b1;
        step();
        bus.ftw_wr = 1'b0;
        check("wrap_wr_pending", int'(bus.ftw_pending), 1);
        cnt = 0;
        while (bus.ftw_pending && cnt < 5000) begin
            step();
            cnt++;
        end
        check("wrap_wr_old_committed", cnt, 512);

        // Enable hold
        t0 = int'(bus.Tri_out);
        bus.en = 1'b0;
        for (int h = 1; h <= 10; h++) begin
            step();
            check("hold_tri", int'(bus.Tri_out), t0);
            if (h == 2) check("hold_valid_still", int'(bus.sine_valid), 1);
            if (h == 3) check("hold_valid_drop", int'(bus.sine_valid), 0);
        end
        bus.en = 1'b1;
        for (int h = 1; h <= 3; h++) begin
            step();
            if (h == 2) check("resume_valid_low", int'(bus.sine_valid), 0);
            if (h == 3) check("resume_valid_rise", int'(bus.sine_valid), 1);
        end

        // Randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            bus.en = ($urandom_range(0, 9) != 0);
            bus.ftw_wr = ($urandom_range(0, 49) == 0);
            bus.ftw_in = $urandom() | 32'h0010_0000;
            step();
        end
        bus.ftw_wr = 1'b0;

        // Mid-operation reset while descending with a retune pending
        bus.en = 1'b1;
        for (int i = 0; i < 3000 && m_up; i++) step();
        bus.ftw_in = 32'h0080_0000;
        bus.ftw_wr = 1'b1;
        step();
        bus.ftw_wr = 1'b0;
        check("pre_rst_pending", int'(bus.ftw_pending), 1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("mid_rst_sine", int'(bus.Sine_out), 0);
        check("mid_rst_tri", int'(bus.Tri_out), 0);
        check("mid_rst_valid", int'(bus.sine_valid), 0);
        check("mid_rst_valley", int'(bus.carrier_valley), 0);
        check("mid_rst_pending", int'(bus.ftw_pending), 0);
        step();
        check("restart_tri_up", int'(bus.Tri_out), 64);
        repeat (1030) step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
